// File: rtl/trivium_keystream_gen.sv
// rtl/trivium_keystream_gen.sv - Trivium keystream generator packing z bits into valid/ready blocks
module trivium_keystream_gen #(
  parameter int DATA_WIDTH     = 80,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [79:0]           key,
  input  logic [79:0]           iv,
  input  logic                  start,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  // W cycles of discarded warm-up (1152 steps), F cycles to fill one block
  localparam int W   = 1152 / BITS_PER_CYCLE;
  localparam int F   = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int WCW = $clog2(W + 1);
  localparam int FCW = $clog2(F + 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(W - 1);
  localparam logic [FCW-1:0] F_LAST = FCW'(F - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [287:0]            ks_q, ks_d;          // ks_q[i-1] holds Trivium bit s_i
  logic [WCW-1:0]          wcnt_q, wcnt_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  logic [DATA_WIDTH-1:0]   fill_q, fill_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  logic [287:0]            step_s;
  logic [BITS_PER_CYCLE-1:0] step_z;
  logic                    t1, t2, t3;
  logic                    xfer;
  logic [287:0]            ks_load;

  // Load layout: K into s1..s80, IV into s94..s173, ones in s286..s288
  assign ks_load = {3'b111, 108'b0, 4'b0, iv, 13'b0, key};

  // BITS_PER_CYCLE chained cipher steps; the earlier step's z lands in the lower bit
  always_comb begin
    step_s = ks_q;
    step_z = '0;
    t1     = 1'b0;
    t2     = 1'b0;
    t3     = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      t1        = step_s[65] ^ step_s[92];
      t2        = step_s[161] ^ step_s[176];
      t3        = step_s[242] ^ step_s[287];
      step_z[i] = t1 ^ t2 ^ t3;
      t1        = t1 ^ (step_s[90] & step_s[91]) ^ step_s[170];
      t2        = t2 ^ (step_s[174] & step_s[175]) ^ step_s[263];
      t3        = t3 ^ (step_s[285] & step_s[286]) ^ step_s[68];
      step_s    = {step_s[286:177], t2, step_s[175:93], t1, step_s[91:0], t3};
    end
  end

  // Next-state logic: warm-up, block filling, output hand-off and start override
  always_comb begin
    state_d     = state_q;
    ks_d        = ks_q;
    wcnt_d      = wcnt_q;
    fcnt_d      = fcnt_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    xfer        = out_valid_q & out_ready;

    if (xfer) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
      end
      WARMUP: begin
        ks_d = step_s;
        if (wcnt_q == W_LAST) begin
          state_d = RUN;
          wcnt_d  = '0;
          fcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      RUN: begin
        ks_d = step_s;
        for (int k = 0; k < F; k++) begin
          if (fcnt_q == FCW'(k)) begin
            fill_d[k*BITS_PER_CYCLE +: BITS_PER_CYCLE] = step_z;
          end
        end
        if (fcnt_q == F_LAST) begin
          if (!out_valid_q || xfer) begin
            out_data_d  = fill_d;
            out_valid_d = 1'b1;
            fcnt_d      = '0;
          end else begin
            // Output register still owned by the consumer; park the full block
            state_d = STALL;
          end
        end else begin
          fcnt_d = fcnt_q + FCW'(1);
        end
      end
      STALL: begin
        if (out_ready) begin
          out_data_d  = fill_q;
          out_valid_d = 1'b1;
          fcnt_d      = '0;
          state_d     = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A rekey wins over everything, including a transfer in the same cycle
    if (start) begin
      state_d     = WARMUP;
      ks_d        = ks_load;
      wcnt_d      = '0;
      fcnt_d      = '0;
      fill_d      = '0;
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ks_q        <= '0;
      wcnt_q      <= '0;
      fcnt_q      <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ks_q        <= ks_d;
      wcnt_q      <= wcnt_d;
      fcnt_q      <= fcnt_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q == WARMUP);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// tb/tb_trivium_keystream_gen.sv - self-checking bench for trivium_keystream_gen
module tb_trivium_keystream_gen;

  logic        clk;
  logic        rst;
  logic [79:0] key_a, iv_a, key_b, iv_b;
  logic        start_a, start_b, ready_a, ready_b;
  logic        busy_a, busy_b, out_valid_a, out_valid_b;
  logic [79:0] out_data_a;
  logic [63:0] out_data_b;

  bit          sel;
  logic        busy_m, out_valid_m;
  logic [79:0] out_data_m;

  int n_checks = 0;
  int n_fail   = 0;

  bit gold [0:12799];

  typedef struct {
    bit          sel_b;
    logic [79:0] key;
    logic [79:0] iv;
    int          n_blocks;
    int          ready_pct;
    int          exp_first;
  } scen_t;

  scen_t tbl [4];

  trivium_keystream_gen dut_a (
    .clk(clk), .rst(rst), .key(key_a), .iv(iv_a), .start(start_a),
    .busy(busy_a), .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(ready_a)
  );

  trivium_keystream_gen #(.DATA_WIDTH(64), .BITS_PER_CYCLE(8)) dut_b (
    .clk(clk), .rst(rst), .key(key_b), .iv(iv_b), .start(start_b),
    .busy(busy_b), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(ready_b)
  );

  assign busy_m      = sel ? busy_b : busy_a;
  assign out_valid_m = sel ? out_valid_b : out_valid_a;
  assign out_data_m  = sel ? {16'h0, out_data_b} : out_data_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reference built from the three separate shift registers A, B, C
  task automatic gen_gold(input logic [79:0] k, input logic [79:0] v, input int nbits);
    bit a [1:93];
    bit b [1:84];
    bit c [1:111];
    bit x1, x2, x3;
    for (int i = 1; i <= 93; i++) a[i] = (i <= 80) ? k[i-1] : 1'b0;
    for (int i = 1; i <= 84; i++) b[i] = (i <= 80) ? v[i-1] : 1'b0;
    for (int i = 1; i <= 111; i++) c[i] = (i >= 109);
    for (int n = 0; n < 1152 + nbits; n++) begin
      x1 = a[66] ^ a[93];
      x2 = b[69] ^ b[84];
      x3 = c[66] ^ c[111];
      if (n >= 1152) gold[n-1152] = x1 ^ x2 ^ x3;
      x1 = x1 ^ (a[91] & a[92]) ^ b[78];
      x2 = x2 ^ (b[82] & b[83]) ^ c[87];
      x3 = x3 ^ (c[109] & c[110]) ^ a[69];
      for (int i = 93; i > 1; i--) a[i] = a[i-1];
      for (int i = 84; i > 1; i--) b[i] = b[i-1];
      for (int i = 111; i > 1; i--) c[i] = c[i-1];
      a[1] = x3;
      b[1] = x1;
      c[1] = x2;
    end
  endtask

  function automatic logic [79:0] gold_block(input int idx, input int bw);
    logic [79:0] r;
    r = '0;
    for (int j = 0; j < bw; j++) r[j] = gold[idx*bw + j];
    return r;
  endfunction

  task automatic set_ready(input logic r);
    if (sel) ready_b = r;
    else     ready_a = r;
  endtask

  task automatic start_pulse(input logic [79:0] k, input logic [79:0] v);
    if (sel) begin
      key_b = k; iv_b = v; start_b = 1'b1;
    end else begin
      key_a = k; iv_a = v; start_a = 1'b1;
    end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_first_valid(input string name, input int exp);
    int c;
    c = 0;
    while (!out_valid_m && c < 3000) begin
      tick();
      c++;
    end
    check(name, c, exp);
  endtask

  task automatic run_scen(input scen_t s, input int idx);
    int c, got, last, bw, fc, wc, busy_cnt, limit;
    bit first_seen, prev_hold, r;
    logic [79:0] prev_data;
    sel = s.sel_b;
    bw  = s.sel_b ? 64 : 80;
    fc  = s.sel_b ? 8 : 80;
    wc  = s.sel_b ? 144 : 1152;
    gen_gold(s.key, s.iv, s.n_blocks * bw);
    set_ready(1'b0);
    start_pulse(s.key, s.iv);
    c = 0; got = 0; last = 0; busy_cnt = 0;
    first_seen = 0; prev_hold = 0; prev_data = '0;
    limit = s.exp_first + s.n_blocks * fc * 40 + 200;
    while (got < s.n_blocks && c < limit) begin
      if (busy_m) busy_cnt++;
      if (out_valid_m && !first_seen) begin
        first_seen = 1;
        check($sformatf("scen%0d_first_valid_cycle", idx), c, s.exp_first);
      end
      if (prev_hold) begin
        check($sformatf("scen%0d_hold_valid_c%0d", idx, c), out_valid_m, 1'b1);
        check($sformatf("scen%0d_hold_data_c%0d", idx, c), out_data_m, prev_data);
      end
      r = ($urandom_range(99) < s.ready_pct);
      set_ready(r);
      if (out_valid_m && r) begin
        check($sformatf("scen%0d_block%0d", idx, got), out_data_m, gold_block(got, bw));
        if (s.ready_pct == 100 && got > 0)
          check($sformatf("scen%0d_gap%0d", idx, got), c - last, fc);
        last = c;
        got++;
      end
      prev_hold = out_valid_m && !r;
      prev_data = out_data_m;
      tick();
      c++;
    end
    check($sformatf("scen%0d_blocks_received", idx), got, s.n_blocks);
    check($sformatf("scen%0d_busy_cycles", idx), busy_cnt, wc);
  endtask

  initial begin
    int idle_viol;
    logic [79:0] blk;

    tbl[0] = '{1'b0, 80'h0, 80'h0, 16, 100, 1232};
    tbl[1] = '{1'b1, 80'h0123456789ABCDEF0123, 80'h1, 20, 100, 152};
    tbl[2] = '{1'b0, 80'h0123456789ABCDEF0123, 80'h1, 16, 100, 1232};
    tbl[3] = '{1'b1, 80'h0123456789ABCDEF0123, 80'h1, 200, 30, 152};

    rst = 1'b1;
    key_a = '0; iv_a = '0; key_b = '0; iv_b = '0;
    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
    sel = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("reset_valid_a", out_valid_a, 1'b0);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_data_a", out_data_a, 80'h0);
    check("reset_valid_b", out_valid_b, 1'b0);
    check("reset_busy_b", busy_b, 1'b0);
    check("reset_data_b", out_data_b, 64'h0);

    idle_viol = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (out_valid_a || busy_a || out_data_a != 80'h0) idle_viol++;
      if (out_valid_b || busy_b || out_data_b != 64'h0) idle_viol++;
    end
    check("idle_quiet_cycles_violating", idle_viol, 0);

    for (int i = 0; i < 4; i++) run_scen(tbl[i], i);

    // Rekey in the middle of warm-up on the default-width instance
    sel = 1'b0;
    set_ready(1'b1);
    start_pulse(80'hFEDCBA9876543210FFEE, 80'h00112233445566778899);
    repeat (499) tick();
    check("midwarm_busy", busy_m, 1'b1);
    gen_gold(80'h13579BDF02468ACE1357, 80'hCAFEBABE0000DEADBEEF, 80);
    start_pulse(80'h13579BDF02468ACE1357, 80'hCAFEBABE0000DEADBEEF);
    wait_first_valid("midwarm_restart_latency", 1232);
    check("midwarm_first_block", out_data_m, gold_block(0, 80));

    // Park a block in STALL, then rekey while a transfer is offered
    sel = 1'b1;
    set_ready(1'b0);
    gen_gold(80'hA5A5A5A5A5A5A5A5A5A5, 80'h5A5A5A5A5A5A5A5A5A5A, 64);
    blk = gold_block(0, 64);
    start_pulse(80'hA5A5A5A5A5A5A5A5A5A5, 80'h5A5A5A5A5A5A5A5A5A5A);
    wait_first_valid("stall_first_latency", 152);
    repeat (10) tick();
    check("stall_valid_held", out_valid_m, 1'b1);
    check("stall_data_held", out_data_m, blk);
    gen_gold(80'h0F0F0F0F0F0F0F0F0F0F, 80'h3C3C3C3C3C3C3C3C3C3C, 64);
    key_b = 80'h0F0F0F0F0F0F0F0F0F0F;
    iv_b  = 80'h3C3C3C3C3C3C3C3C3C3C;
    start_b = 1'b1;
    ready_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("stall_start_valid_cleared", out_valid_m, 1'b0);
    check("stall_start_busy", busy_m, 1'b1);
    wait_first_valid("stall_restart_latency", 152);
    check("stall_restart_first_block", out_data_m, gold_block(0, 64));

    // Reset while running returns both instances to idle with no auto-start
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("run_reset_valid_a", out_valid_a, 1'b0);
    check("run_reset_busy_a", busy_a, 1'b0);
    check("run_reset_data_a", out_data_a, 80'h0);
    check("run_reset_valid_b", out_valid_b, 1'b0);
    check("run_reset_busy_b", busy_b, 1'b0);
    check("run_reset_data_b", out_data_b, 64'h0);
    repeat (300) tick();
    check("post_reset_idle_valid_b", out_valid_b, 1'b0);
    check("post_reset_idle_busy_a", busy_a, 1'b0);
    check("post_reset_idle_busy_b", busy_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trivium_keystream_gen.md
# trivium_keystream_gen

Parametrised Trivium keystream generator that packs keystream into DATA_WIDTH-bit blocks and delivers them on a valid/ready stream. It is the next generation of the single-bit Trivium block wrapper. It adds the following:
- an internal 288-bit cipher core unrolled to BITS_PER_CYCLE steps per clock;
- an explicit start/rekey input;
- a double-buffered output, so consecutive blocks stream without bubbles.

It sits between key/IV management and stream-cipher consumers (XOR datapaths, PRNG users).

## Interface
- DATA_WIDTH, 80: output block width in bits. Must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1: Trivium steps per clock. Allowed values are 1, 2, 4, 8, 16, 32, 64. Must divide 1152.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- key  in  80  cipher key, sampled only in the cycle start=1. K1..K80 = key[0]..key[79].
- iv  in  80  initial vector, sampled only in the cycle start=1. IV1..IV80 = iv[0]..iv[79].
- start  in  1  one-cycle pulse: load key/iv and begin warm-up. Accepted in any state.
- busy  out  1  high while warm-up is in progress.
- out_data  out  DATA_WIDTH  keystream block. Keystream bit z1 of the block is at out_data[0]; zDATA_WIDTH is at the MSB.
- out_valid  out  1  out_data holds an unconsumed block.
- out_ready  in  1  consumer accepts the block. A transfer occurs when out_valid & out_ready.

## Operation
- Cipher state s1..s288 is loaded on start:
  - s1..s93 = K1..K80, then 13 zeros;
  - s94..s177 = IV1..IV80, then 4 zeros;
  - s178..s288 = 108 zeros, then 1,1,1.
- One step:
  - t1=s66^s93, t2=s162^s177, t3=s243^s288, z=t1^t2^t3.
  - t1^=s91&s92^s171, t2^=s175&s176^s264, t3^=s286&s287^s69.
  - Shift: s1..s93 ← t3,s1..s92; s94..s177 ← t1,s94..s176; s178..s288 ← t2,s178..s287.
- Each enabled cycle performs BITS_PER_CYCLE chained steps combinationally. The earlier step's z takes the lower bit index.
- Derived constants: W = 1152/BITS_PER_CYCLE warm-up cycles; F = DATA_WIDTH/BITS_PER_CYCLE fill cycles per block.
- Internal storage:
  - fill register (DATA_WIDTH) with fill counter (clog2(F+1) bits);
  - output register (out_data/out_valid);
  - warm-up counter (clog2(W+1) bits).
- FSM states and transitions:
  - IDLE: cipher disabled, outputs held. start → WARMUP.
  - WARMUP: step every cycle, z discarded, busy=1. Warm-up counter reaches W-1 → RUN, with fill counter = 0.
  - RUN: step every cycle, BITS_PER_CYCLE z bits written to fill bits [cnt·BPC +: BPC]. On the last fill cycle (cnt=F-1):
    - if out_valid=0, or a transfer occurs this cycle: the completed block loads into the output register, out_valid=1, cnt wraps to 0, stay RUN;
    - otherwise go to STALL.
  - STALL: cipher disabled, fill block held. If out_ready=1: the block moves to the output register (out_valid stays 1), cnt=0 → RUN. The cipher does not step in this cycle.
- Transfer with no new block arriving: out_valid → 0 next cycle. out_data keeps its last value.
- start in any state (including mid-warm-up, RUN, STALL):
  - reloads the cipher state, clears both counters, the fill register and out_valid, then → WARMUP;
  - start overrides a simultaneous transfer. That transfer still counts as completed for the consumer.
- Keystream continuity: concatenating accepted blocks in order yields z1, z2, … with no bit lost or repeated, independent of out_ready pattern.

## Timing
- Reset values: state IDLE; busy=0, out_valid=0, out_data=0; counters 0; cipher state 0.
- No automatic start after reset.
- start sampled at edge T:
  - busy=1 from cycle T+1 through T+W;
  - first block out_valid=1 at cycle T+W+F+1.
  - Example, defaults: T+1233. With BITS_PER_CYCLE=8, DATA_WIDTH=64: T+153.
- Sustained throughput with out_ready held 1: one block every F cycles.
- STALL costs exactly one extra cycle per stalled block after out_ready returns.
- out_valid/out_data change only on clock edges. No combinational path from out_ready to out_valid/out_data.

## Test plan
- Reset then idle 2000 cycles, no start → out_valid=0, busy=0, out_data=0 throughout.
- Defaults, key=0, iv=0, start at T, out_ready=1 → busy high for exactly 1152 cycles. First out_valid at T+1233. 16 consecutive blocks 80 cycles apart match the bit-serial golden model z1..z1280.
- BITS_PER_CYCLE=8, DATA_WIDTH=64, key=80'h0123456789ABCDEF0123, iv=80'h1 → blocks bit-identical to BITS_PER_CYCLE=1 run. First valid at T+153, then every 8 cycles.
- Random out_ready (30% duty) for 200 blocks → concatenated accepted data equals golden stream. out_data is stable while out_valid & !out_ready.
- start asserted mid-warm-up (T+500), and again in STALL with out_valid=1 and out_ready=1 in the same cycle → out_valid=0 next cycle. The stream restarts from z1 of the new key/iv, first valid W+F+1 cycles after the last start.
- rst asserted in RUN → next cycle all outputs at reset values, state IDLE.
